// File: rtl/fifo_rd_stream_pkg.sv
// fifo_rd_stream_pkg
// Shared constants and types for the FIFO read-side stream consumer.
//   FIFO_DATA_WIDTH : default width of FIFO words and stream data
//   FIFO_RD_LATENCY : cycles from an accepted read enable to valid read data
//   BEAT_IDX_W      : width of the in-packet beat index
package fifo_rd_stream_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_RD_LATENCY = 1;
  localparam int BEAT_IDX_W      = 8;

  typedef logic [BEAT_IDX_W-1:0] beat_idx_t;

  // The index of the final beat of a packet, truncated to the beat index
  // width so a 256-beat packet ends on 255.
  function automatic beat_idx_t last_beat_idx(input int pkt_len);
    return beat_idx_t'(pkt_len - 1);
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if
// Bundles the FIFO read port and the outgoing valid/ready stream.
//   master : the stream consumer block (drives fifo_rd_en and the stream)
//   slave  : the environment (FIFO read side and downstream sink)
interface fifo_rd_stream_if
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
);

  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (
    input  fifo_empty, fifo_rd_data, m_ready,
    output fifo_rd_en, m_valid, m_data, m_last
  );

  modport slave (
    output fifo_empty, fifo_rd_data, m_ready,
    input  fifo_rd_en, m_valid, m_data, m_last
  );

endinterface

// File: rtl/fifo_rd_stream_skid_buf.sv
// stream_skid_buf
// Two-entry registered valid/ready buffer (head + skid). The writer must
// never push into a full buffer; there is no in_ready.
//   clk, rst_n : clock and asynchronous active-low reset
//   in_valid   : write strobe, in_data captured on the next edge
//   out_valid  : head holds data (occ != 0)
//   out_ready  : downstream accepts head this cycle
//   out_data   : head register, no combinational input path
//   occ        : current occupancy, 0..2
module stream_skid_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occ
);

  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic [1:0]            occ_q, occ_d;
  logic [1:0]            occ_after_pop;
  logic                  pop;

  // Pop first, then decide where an incoming word lands: the head if it is
  // free once this cycle's pop has happened, otherwise the skid slot. When
  // popping a full buffer the skid word advances into the head, so a word
  // arriving in the same edge goes behind it and order is preserved.
  always_comb begin
    pop           = (occ_q != 2'd0) && out_ready;
    occ_after_pop = occ_q - {1'b0, pop};
    head_d        = head_q;
    skid_d        = skid_q;
    if (pop && (occ_q == 2'd2)) begin
      head_d = skid_q;
    end
    if (in_valid) begin
      if (occ_after_pop == 2'd0) begin
        head_d = in_data;
      end else begin
        skid_d = in_data;
      end
    end
    occ_d = occ_after_pop + {1'b0, in_valid};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      skid_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      skid_q <= skid_d;
      occ_q  <= occ_d;
    end
  end

  assign out_valid = (occ_q != 2'd0);
  assign out_data  = head_q;
  assign occ       = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
// Read-side consumer of the dual-clock FIFO, entirely in the rclk domain.
// Issues FIFO reads, tracks the one-cycle read latency, buffers returning
// words in a two-entry skid buffer and frames the stream into PKT_LEN-beat
// packets.
//   rclk, rrst_n : read clock and asynchronous active-low reset
//   en           : allows new FIFO reads; buffered data drains regardless
//   bus          : FIFO read port (fifo_empty/fifo_rd_en/fifo_rd_data) and
//                  stream (m_valid/m_ready/m_data/m_last)
//   beat_idx     : index of the current head beat within its packet
//   pkt_cnt      : completed packets, wrapping
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int PKT_LEN    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic                 en,
  fifo_rd_stream_if.master     bus,
  output logic [BEAT_IDX_W-1:0] beat_idx,
  output logic [CNT_WIDTH-1:0] pkt_cnt
);

  localparam beat_idx_t LAST_IDX = last_beat_idx(PKT_LEN);

  logic                 inflight_q, inflight_d;
  beat_idx_t            beat_idx_q, beat_idx_d;
  logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [1:0]           occ;
  logic                 head_valid;
  logic                 pop;
  logic                 last;
  logic                 rd_en;
  logic [2:0]           committed;

  stream_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid_buf (
    .clk       (rclk),
    .rst_n     (rrst_n),
    .in_valid  (inflight_q),
    .in_data   (bus.fifo_rd_data),
    .out_ready (bus.m_ready),
    .out_valid (head_valid),
    .out_data  (bus.m_data),
    .occ       (occ)
  );

  // A read is issued only if the word it returns next cycle is guaranteed a
  // slot: buffered plus in-flight words, less this cycle's pop, must leave
  // room. Reads are suppressed while reset is held.
  always_comb begin
    pop        = head_valid && bus.m_ready;
    last       = head_valid && (beat_idx_q == LAST_IDX);
    committed  = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
    rd_en      = rrst_n && en && !bus.fifo_empty && (committed < 3'd2);
    inflight_d = rd_en;
  end

  // Framing only advances on accepted beats, so stalls of any kind (en low,
  // empty FIFO, backpressure) leave the position in the packet untouched.
  always_comb begin
    beat_idx_d = beat_idx_q;
    pkt_cnt_d  = pkt_cnt_q;
    if (pop) begin
      if (beat_idx_q == LAST_IDX) begin
        beat_idx_d = '0;
        pkt_cnt_d  = pkt_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        beat_idx_d = beat_idx_q + 8'd1;
      end
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      inflight_q <= 1'b0;
      beat_idx_q <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      inflight_q <= inflight_d;
      beat_idx_q <= beat_idx_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = head_valid;
  assign bus.m_last     = last;
  assign beat_idx       = beat_idx_q;
  assign pkt_cnt        = pkt_cnt_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream
// Directed bench for fifo_rd_stream. Two instances share one behavioural
// FIFO: dut0 with PKT_LEN=4 and dut1 with PKT_LEN=1, selected by sel.
module tb_fifo_rd_stream;
  import fifo_rd_stream_pkg::*;

  logic       rclk   = 1'b0;
  logic       rrst_n = 1'b0;
  logic       en0    = 1'b0;
  logic       en1    = 1'b0;
  logic       ready0 = 1'b0;
  logic       ready1 = 1'b0;
  logic       sel    = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] rd_data    = 8'h00;
  logic [7:0] q[$];
  logic [7:0] beat_idx0, beat_idx1;
  logic [15:0] pkt_cnt0, pkt_cnt1;
  logic       rd_en;
  int         checks = 0;
  int         fails  = 0;

  always #5 rclk = ~rclk;

  fifo_rd_stream_if #(.DATA_WIDTH(8)) if0 ();
  fifo_rd_stream_if #(.DATA_WIDTH(8)) if1 ();

  assign if0.fifo_empty   = sel ? 1'b1 : fifo_empty;
  assign if1.fifo_empty   = sel ? fifo_empty : 1'b1;
  assign if0.fifo_rd_data = rd_data;
  assign if1.fifo_rd_data = rd_data;
  assign if0.m_ready      = ready0;
  assign if1.m_ready      = ready1;
  assign rd_en            = sel ? if1.fifo_rd_en : if0.fifo_rd_en;

  fifo_rd_stream #(.DATA_WIDTH(8), .PKT_LEN(4), .CNT_WIDTH(16)) dut0 (
    .rclk(rclk), .rrst_n(rrst_n), .en(en0), .bus(if0),
    .beat_idx(beat_idx0), .pkt_cnt(pkt_cnt0)
  );

  fifo_rd_stream #(.DATA_WIDTH(8), .PKT_LEN(1), .CNT_WIDTH(16)) dut1 (
    .rclk(rclk), .rrst_n(rrst_n), .en(en1), .bus(if1),
    .beat_idx(beat_idx1), .pkt_cnt(pkt_cnt1)
  );

  // Behavioural FIFO read side: one-cycle read latency, registered empty,
  // reset together with the consumer.
  always @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      q.delete();
      rd_data    <= 8'h00;
      fifo_empty <= 1'b1;
    end else begin
      if (rd_en && !fifo_empty) begin
        rd_data <= q.pop_front();
      end
      fifo_empty <= (q.size() == 0);
    end
  end

  task automatic push(input logic [7:0] d);
    q.push_back(d);
    fifo_empty = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge rclk);
    rrst_n = 1'b0;
    en0 = 1'b0; en1 = 1'b0; ready0 = 1'b0; ready1 = 1'b0;
    @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  // Outputs are forced clear while reset is held, even with reads requested.
  task automatic test_reset();
    #2;
    en0 = 1'b1; ready0 = 1'b1;
    push(8'h55);
    #1;
    checks++; if (if0.fifo_rd_en !== 1'b0) begin fails++; $display("[TB] FAIL rst_rd_en: got %b expected 0", if0.fifo_rd_en); end
    checks++; if (if0.m_valid !== 1'b0) begin fails++; $display("[TB] FAIL rst_valid: got %b expected 0", if0.m_valid); end
    checks++; if (if0.m_data !== 8'h00) begin fails++; $display("[TB] FAIL rst_data: got %h expected 00", if0.m_data); end
    checks++; if (if0.m_last !== 1'b0) begin fails++; $display("[TB] FAIL rst_last: got %b expected 0", if0.m_last); end
    checks++; if (beat_idx0 !== 8'd0) begin fails++; $display("[TB] FAIL rst_beat: got %0d expected 0", beat_idx0); end
    checks++; if (pkt_cnt0 !== 16'd0) begin fails++; $display("[TB] FAIL rst_pkt: got %0d expected 0", pkt_cnt0); end
    checks++; if (if1.m_last !== 1'b0) begin fails++; $display("[TB] FAIL rst_last_len1: got %b expected 0", if1.m_last); end
    @(negedge rclk); #1;
    checks++; if (if0.m_valid !== 1'b0) begin fails++; $display("[TB] FAIL rst_valid_clk: got %b expected 0", if0.m_valid); end
    checks++; if (if0.fifo_rd_en !== 1'b0) begin fails++; $display("[TB] FAIL rst_rd_en_clk: got %b expected 0", if0.fifo_rd_en); end
  endtask

  task automatic test_throughput();
    logic [7:0] exp_d;
    logic       exp_l;
    do_reset();
    sel = 1'b0;
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    en0 = 1'b1; ready0 = 1'b1;
    @(negedge rclk); #1;
    checks++; if (if0.m_valid !== 1'b0) begin fails++; $display("[TB] FAIL thr_startup: got %b expected 0", if0.m_valid); end
    for (int i = 0; i < 8; i++) begin
      @(negedge rclk); #1;
      exp_d = 8'h10 + 8'(i);
      exp_l = ((i % 4) == 3);
      checks++; if (if0.m_valid !== 1'b1) begin fails++; $display("[TB] FAIL thr_valid[%0d]: got %b expected 1", i, if0.m_valid); end
      checks++; if (if0.m_data !== exp_d) begin fails++; $display("[TB] FAIL thr_data[%0d]: got %h expected %h", i, if0.m_data, exp_d); end
      checks++; if (if0.m_last !== exp_l) begin fails++; $display("[TB] FAIL thr_last[%0d]: got %b expected %b", i, if0.m_last, exp_l); end
      checks++; if (beat_idx0 !== 8'(i % 4)) begin fails++; $display("[TB] FAIL thr_beat[%0d]: got %0d expected %0d", i, beat_idx0, i % 4); end
    end
    @(negedge rclk); #1;
    checks++; if (if0.m_valid !== 1'b0) begin fails++; $display("[TB] FAIL thr_drained: got %b expected 0", if0.m_valid); end
    checks++; if (pkt_cnt0 !== 16'd2) begin fails++; $display("[TB] FAIL thr_pkt_cnt: got %0d expected 2", pkt_cnt0); end
  endtask

  // Ready pattern 1,0,0 repeating. Outstanding = reads issued - beats taken,
  // which must never exceed the two buffer slots.
  task automatic test_backpressure();
    int         rx;
    int         outstanding;
    int         issue;
    int         popv;
    logic       hold;
    logic [7:0] hold_data;
    logic [7:0] exp_d;
    rx = 0; outstanding = 0; hold = 1'b0; hold_data = 8'h00;
    do_reset();
    sel = 1'b0;
    for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
    en0 = 1'b1;
    for (int cyc = 0; cyc < 80 && rx < 8; cyc++) begin
      @(negedge rclk);
      ready0 = ((cyc % 3) == 0);
      #1;
      if (hold) begin
        checks++;
        if (if0.m_valid !== 1'b1 || if0.m_data !== hold_data) begin
          fails++; $display("[TB] FAIL bp_stable: got valid=%b data=%h expected valid=1 data=%h", if0.m_valid, if0.m_data, hold_data);
        end
      end
      issue = (rd_en && !fifo_empty) ? 1 : 0;
      popv  = (if0.m_valid && ready0) ? 1 : 0;
      checks++;
      if (outstanding + issue - popv > 2) begin
        fails++; $display("[TB] FAIL bp_occ_limit: got %0d expected <=2", outstanding + issue - popv);
      end
      if (popv == 1) begin
        exp_d = 8'h20 + 8'(rx);
        checks++; if (if0.m_data !== exp_d) begin fails++; $display("[TB] FAIL bp_order[%0d]: got %h expected %h", rx, if0.m_data, exp_d); end
        rx++;
      end
      outstanding = outstanding + issue - popv;
      hold      = if0.m_valid && !ready0;
      hold_data = if0.m_data;
    end
    checks++; if (rx != 8) begin fails++; $display("[TB] FAIL bp_count: got %0d expected 8", rx); end
    ready0 = 1'b1;
    repeat (3) @(negedge rclk);
    #1;
    checks++; if (if0.m_valid !== 1'b0) begin fails++; $display("[TB] FAIL bp_no_dup: got %b expected 0", if0.m_valid); end
  endtask

  task automatic test_empty();
    do_reset();
    sel = 1'b0;
    en0 = 1'b1; ready0 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge rclk); #1;
      checks++; if (if0.fifo_rd_en !== 1'b0) begin fails++; $display("[TB] FAIL empty_rd_en[%0d]: got %b expected 0", i, if0.fifo_rd_en); end
      checks++; if (if0.m_valid !== 1'b0) begin fails++; $display("[TB] FAIL empty_valid[%0d]: got %b expected 0", i, if0.m_valid); end
    end
    @(negedge rclk);
    push(8'hA5);
    #1;
    checks++; if (if0.fifo_rd_en !== 1'b1) begin fails++; $display("[TB] FAIL empty_issue: got %b expected 1", if0.fifo_rd_en); end
    @(negedge rclk); #1;
    checks++; if (if0.m_valid !== 1'b0) begin fails++; $display("[TB] FAIL empty_lat1: got %b expected 0", if0.m_valid); end
    @(negedge rclk); #1;
    checks++; if (if0.m_valid !== 1'b1) begin fails++; $display("[TB] FAIL empty_lat2: got %b expected 1", if0.m_valid); end
    checks++; if (if0.m_data !== 8'hA5) begin fails++; $display("[TB] FAIL empty_data: got %h expected a5", if0.m_data); end
    @(negedge rclk); #1;
    checks++; if (if0.m_valid !== 1'b0) begin fails++; $display("[TB] FAIL empty_single: got %b expected 0", if0.m_valid); end
  endtask

  task automatic test_en_pause();
    int         got;
    logic [7:0] exp_d;
    logic       exp_l;
    do_reset();
    sel = 1'b0;
    push(8'h30); push(8'h31);
    en0 = 1'b1; ready0 = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 20 && got < 2; cyc++) begin
      @(negedge rclk); #1;
      if (if0.m_valid === 1'b1) begin
        exp_d = 8'h30 + 8'(got);
        checks++; if (if0.m_data !== exp_d) begin fails++; $display("[TB] FAIL en_data[%0d]: got %h expected %h", got, if0.m_data, exp_d); end
        checks++; if (beat_idx0 !== 8'(got)) begin fails++; $display("[TB] FAIL en_beat[%0d]: got %0d expected %0d", got, beat_idx0, got); end
        got++;
      end
    end
    checks++; if (got != 2) begin fails++; $display("[TB] FAIL en_first_beats: got %0d expected 2", got); end
    en0 = 1'b0;
    push(8'h32); push(8'h33);
    for (int i = 0; i < 8; i++) begin
      @(negedge rclk); #1;
      checks++; if (if0.fifo_rd_en !== 1'b0) begin fails++; $display("[TB] FAIL en_off_rd[%0d]: got %b expected 0", i, if0.fifo_rd_en); end
    end
    checks++; if (beat_idx0 !== 8'd2) begin fails++; $display("[TB] FAIL en_hold_beat: got %0d expected 2", beat_idx0); end
    checks++; if (if0.m_valid !== 1'b0) begin fails++; $display("[TB] FAIL en_hold_valid: got %b expected 0", if0.m_valid); end
    en0 = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 20 && got < 2; cyc++) begin
      @(negedge rclk); #1;
      if (if0.m_valid === 1'b1) begin
        exp_d = 8'h32 + 8'(got);
        exp_l = (got == 1);
        checks++; if (if0.m_data !== exp_d) begin fails++; $display("[TB] FAIL en_resume_data[%0d]: got %h expected %h", got, if0.m_data, exp_d); end
        checks++; if (beat_idx0 !== 8'(got + 2)) begin fails++; $display("[TB] FAIL en_resume_beat[%0d]: got %0d expected %0d", got, beat_idx0, got + 2); end
        checks++; if (if0.m_last !== exp_l) begin fails++; $display("[TB] FAIL en_resume_last[%0d]: got %b expected %b", got, if0.m_last, exp_l); end
        got++;
      end
    end
    checks++; if (got != 2) begin fails++; $display("[TB] FAIL en_resume_beats: got %0d expected 2", got); end
    @(negedge rclk); #1;
    checks++; if (pkt_cnt0 !== 16'd1) begin fails++; $display("[TB] FAIL en_pkt_cnt: got %0d expected 1", pkt_cnt0); end
    checks++; if (beat_idx0 !== 8'd0) begin fails++; $display("[TB] FAIL en_beat_wrap: got %0d expected 0", beat_idx0); end
  endtask

  // Reset is asserted between clock edges with the buffer full; the outputs
  // must clear before the next rising edge.
  task automatic test_async_reset();
    int got;
    do_reset();
    sel = 1'b0;
    for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
    en0 = 1'b1; ready0 = 1'b0;
    repeat (5) @(negedge rclk);
    #1;
    checks++; if (if0.m_valid !== 1'b1 || if0.m_data !== 8'h40) begin fails++; $display("[TB] FAIL ar_pre: got valid=%b data=%h expected valid=1 data=40", if0.m_valid, if0.m_data); end
    #2;
    rrst_n = 1'b0;
    #1;
    checks++; if (if0.m_valid !== 1'b0) begin fails++; $display("[TB] FAIL ar_valid: got %b expected 0", if0.m_valid); end
    checks++; if (if0.m_data !== 8'h00) begin fails++; $display("[TB] FAIL ar_data: got %h expected 00", if0.m_data); end
    checks++; if (if0.fifo_rd_en !== 1'b0) begin fails++; $display("[TB] FAIL ar_rd_en: got %b expected 0", if0.fifo_rd_en); end
    @(negedge rclk);
    rrst_n = 1'b1;
    ready0 = 1'b1;
    push(8'h01);
    got = 0;
    for (int cyc = 0; cyc < 10 && got < 1; cyc++) begin
      @(negedge rclk); #1;
      if (if0.m_valid === 1'b1) begin
        checks++; if (if0.m_data !== 8'h01) begin fails++; $display("[TB] FAIL ar_first_data: got %h expected 01", if0.m_data); end
        checks++; if (beat_idx0 !== 8'd0) begin fails++; $display("[TB] FAIL ar_first_beat: got %0d expected 0", beat_idx0); end
        got++;
      end
    end
    checks++; if (got != 1) begin fails++; $display("[TB] FAIL ar_first_seen: got %0d expected 1", got); end
    @(negedge rclk); #1;
    checks++; if (if0.m_valid !== 1'b0) begin fails++; $display("[TB] FAIL ar_no_leftover: got %b expected 0", if0.m_valid); end
  endtask

  task automatic test_pkt_len1();
    logic [7:0] exp_tab [3];
    int         got;
    exp_tab = '{8'hFF, 8'h00, 8'h7E};
    do_reset();
    sel = 1'b1;
    push(8'hFF); push(8'h00); push(8'h7E);
    en1 = 1'b1; ready1 = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
      @(negedge rclk); #1;
      if (if1.m_valid === 1'b1) begin
        checks++; if (if1.m_data !== exp_tab[got]) begin fails++; $display("[TB] FAIL len1_data[%0d]: got %h expected %h", got, if1.m_data, exp_tab[got]); end
        checks++; if (if1.m_last !== 1'b1) begin fails++; $display("[TB] FAIL len1_last[%0d]: got %b expected 1", got, if1.m_last); end
        checks++; if (beat_idx1 !== 8'd0) begin fails++; $display("[TB] FAIL len1_beat[%0d]: got %0d expected 0", got, beat_idx1); end
        got++;
      end
    end
    checks++; if (got != 3) begin fails++; $display("[TB] FAIL len1_beats: got %0d expected 3", got); end
    @(negedge rclk); #1;
    checks++; if (pkt_cnt1 !== 16'd3) begin fails++; $display("[TB] FAIL len1_pkt_cnt: got %0d expected 3", pkt_cnt1); end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_throughput();
    test_backpressure();
    test_empty();
    test_en_pause();
    test_async_reset();
    test_pkt_len1();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
